// File: rtl/cpm_pkg.sv
// Shared types and constants for capture_period_meter and its FIFO.
// Optional min/max tracking in the top level is enabled by defining CPM_MINMAX_EN.
package cpm_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CALC     = 2'd1,
    WAIT_CLR = 2'd2
  } cpm_state_e;

  localparam int CPM_W_DEF     = 4;
  localparam int CPM_DEPTH_DEF = 4;

  // Sliced down to W bits by the user; min starts high so the first period always wins.
  localparam logic [31:0] CPM_MIN_RST = 32'hFFFF_FFFF;
  localparam logic [31:0] CPM_MAX_RST = 32'h0000_0000;

endpackage

// File: rtl/cpm_fifo.sv
// Fall-through period FIFO with registered head data/valid and wrap-bit pointers.
// A push while full is accepted only when a pop frees a slot at the same edge.
module cpm_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head_data,
  output logic         head_valid
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
  logic [W-1:0] head_data_reg, head_data_next;
  logic         head_valid_reg;
  logic         push_ok, pop_ok;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    rd_ptr_next = rd_ptr_reg + {{AW{1'b0}}, pop_ok};
    wr_ptr_next = wr_ptr_reg + {{AW{1'b0}}, push_ok};
    // Index match with the new read pointer only happens when the FIFO is about
    // to be empty, so the incoming word bypasses the array straight to the head.
    if (push_ok && (wr_ptr_reg[AW-1:0] == rd_ptr_next[AW-1:0]))
      head_data_next = push_data;
    else
      head_data_next = mem[rd_ptr_next[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      head_data_reg  <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      head_data_reg  <= head_data_next;
      head_valid_reg <= (wr_ptr_next != rd_ptr_next);
    end
  end

  assign head_data  = head_data_reg;
  assign head_valid = head_valid_reg;

endmodule

// File: rtl/capture_period_meter.sv
// Measures the period between successive input captures and queues the results.
// Define CPM_MINMAX_EN to add per_min/per_max tracking of accepted periods.
module capture_period_meter
  import cpm_pkg::*;
#(
  parameter int W     = CPM_W_DEF,
  parameter int DEPTH = CPM_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cap_val,
  input  logic         cap_flag,
  output logic         cap_ack,
  output logic [W-1:0] per_data,
  output logic         per_valid,
  input  logic         per_ready,
  output logic         ovf,
  input  logic         clr_ovf
`ifdef CPM_MINMAX_EN
  ,
  output logic [W-1:0] per_min,
  output logic [W-1:0] per_max
`endif
);

  cpm_state_e   state_reg;
  logic [W-1:0] cur_reg, prev_reg;
  logic         primed_reg;
  logic         cap_ack_reg;
  logic         ovf_reg;

  logic [W-1:0] diff;
  logic         push, pop_fire, drop;
  logic         fifo_full, fifo_empty;

  // Natural W-bit wrap gives the modular period directly.
  assign diff     = cur_reg - prev_reg;
  assign push     = (state_reg == CALC) && primed_reg;
  assign pop_fire = per_ready && !fifo_empty;
  assign drop     = push && fifo_full && !pop_fire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      cur_reg     <= '0;
      prev_reg    <= '0;
      primed_reg  <= 1'b0;
      cap_ack_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cap_flag) begin
            cur_reg     <= cap_val;
            cap_ack_reg <= 1'b1;
            state_reg   <= CALC;
          end
        end
        CALC: begin
          prev_reg   <= cur_reg;
          primed_reg <= 1'b1;
          state_reg  <= WAIT_CLR;
        end
        WAIT_CLR: begin
          if (!cap_flag) begin
            cap_ack_reg <= 1'b0;
            state_reg   <= IDLE;
          end
        end
        default: begin
          cap_ack_reg <= 1'b0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf_reg <= 1'b0;
    else if (drop)
      ovf_reg <= 1'b1;
    else if (clr_ovf)
      ovf_reg <= 1'b0;
  end

  cpm_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (diff),
    .pop        (per_ready),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_data  (per_data),
    .head_valid (per_valid)
  );

  assign cap_ack = cap_ack_reg;
  assign ovf     = ovf_reg;

`ifdef CPM_MINMAX_EN
  logic [W-1:0] per_min_reg, per_max_reg;
  logic         accept;

  assign accept = push && !drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_min_reg <= CPM_MIN_RST[W-1:0];
      per_max_reg <= CPM_MAX_RST[W-1:0];
    end else if (clr_ovf) begin
      per_min_reg <= CPM_MIN_RST[W-1:0];
      per_max_reg <= CPM_MAX_RST[W-1:0];
    end else if (accept) begin
      if (diff < per_min_reg) per_min_reg <= diff;
      if (diff > per_max_reg) per_max_reg <= diff;
    end
  end

  assign per_min = per_min_reg;
  assign per_max = per_max_reg;
`endif

endmodule

// File: doc/capture_period_meter.md
# capture_period_meter

Downstream consumer of the `input_capture` block. It takes each captured counter value when the capture interrupt flag rises and acknowledges the capture by driving the flag-clear line. It computes the modular difference from the previous capture, i.e. the signal period in counter ticks. Results are queued in a small FIFO with a valid/ready output handshake, so software or a later stage can drain periods at its own pace.

## Interface
- `W`, 4: capture counter width; must match the capture block's `val` width.
- `DEPTH`, 4: period FIFO depth; power of two, ≥2.
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  reset, asynchronous and active-high; clears all state.
- `cap_val`  input  W  captured counter value; connects to the capture block's `val`.
- `cap_flag`  input  1  capture interrupt flag; connects to the capture block's `intFlag`.
- `cap_ack`  output  1  flag-clear request; connects to the capture block's `rstIntFlag`.
- `per_data`  output  W  period at the FIFO head, in counter ticks, mod 2^W.
- `per_valid`  output  1  `per_data` holds a valid entry.
- `per_ready`  input  1  consumer accepts the head entry.
- `ovf`  output  1  sticky flag: a period was dropped because the FIFO was full.
- `clr_ovf`  input  1  synchronous clear for `ovf`.
- `per_min`, `per_max`  output  W  only when `CPM_MINMAX_EN` is defined.

## Operation
- **FSM states:** IDLE, CALC, WAIT_CLR.
- **IDLE:**
  - `cap_flag`=1 at an edge: `cur` ← `cap_val`, `cap_ack` ← 1, go to CALC.
  - Otherwise stay in IDLE.
- **CALC (exactly one cycle):**
  - If `primed`: push `diff` = (`cur` − `prev`) mod 2^W, using W-bit wrap-around subtraction.
  - Always: `prev` ← `cur`, `primed` ← 1, go to WAIT_CLR.
- **WAIT_CLR:**
  - Hold `cap_ack`=1 until `cap_flag` is sampled 0.
  - Then `cap_ack` ← 0 and go to IDLE.
  - The next capture is therefore only taken after the flag has deasserted and risen again.
- **First capture after reset:** only primes `prev`; no period is produced.
- **`diff`=0:** pushed as 0. It means a period that is a multiple of 2^W and cannot be resolved; no special flag is raised.
- **FIFO:**
  - Fall-through: the head is visible on `per_data` whenever `per_valid`=1.
  - Pop happens when `per_valid` && `per_ready` at an edge.
- **Full push:** the entry is dropped, `ovf` ← 1, and FIFO contents are unchanged.
- **Push and pop at the same edge while full:** both happen; no drop, `ovf` unchanged.
- **`ovf` update:** `clr_ovf` clears it. If `clr_ovf` and a drop occur at the same edge, `ovf` ends at 1 (set wins).
- **Ignored input:** `cap_val` is not sampled in CALC or WAIT_CLR.

## Timing
- **Reset values:**
  - FSM in IDLE; `cap_ack`=0, `per_valid`=0, `per_data`=0, `ovf`=0.
  - `primed`=0, `prev`=0, FIFO empty.
  - With the macro: `per_min`=all-ones, `per_max`=0.
- **Capture latency:** `cap_flag` sampled high at edge N →
  - `cap_ack`=1 after N;
  - push at N+1;
  - with the FIFO previously empty, `per_valid`=1 after N+1.
- **Flag deassertion:** `cap_flag` sampled low at edge M in WAIT_CLR → `cap_ack`=0 after M. Minimum IDLE-to-IDLE turnaround is 3 cycles.
- **Throughput:** one capture per 3 cycles.
- **Reset mid-operation:**
  - Asynchronous reset in any state drops `cap_ack` immediately and empties the FIFO.
  - `primed` clears, so the next capture re-primes.
- **Stable outputs:** `per_data` and `per_valid` are registered. `per_data` is stable while `per_valid`=1 and `per_ready`=0.

## Configuration
- **`CPM_MINMAX_EN` defined:**
  - Registered `per_min` and `per_max` track the extreme of every period accepted into the FIFO. They update at the same edge as the push.
  - Dropped periods are not tracked.
  - Both return to their reset values on `rst` and when `clr_ovf`=1.
- **Undefined:** the `per_min`/`per_max` ports and their logic are absent; all other behaviour is identical.

## Structure
- **Package `cpm_pkg`:**
  - FSM state enum (IDLE, CALC, WAIT_CLR).
  - Default-width constants for `W` and `DEPTH`.
  - The min/max reset-value constants.
- **Sub-module `cpm_fifo`:**
  - Parameterized by `W` and `DEPTH`.
  - Push/pop interface plus full/empty outputs.
  - Pointers with wrap bits.
- **Top level:** FSM, `cur`/`prev`/`primed` registers, subtractor, `ovf`, and the optional min/max logic.

## Test plan
- **Basic period (W=4):** captures of 3 then 11, with `per_ready`=1 → `per_data`=8, `per_valid` for 1 cycle. The first capture produces no entry.
- **Wrap-around:** captures 13 then 2 → `per_data`=5. Captures 7 then 7 → `per_data`=0.
- **Handshake:**
  - Hold `cap_flag`=1 for 6 cycles → `cap_ack` stays high throughout, and exactly one push occurs.
  - `cap_ack` falls one edge after `cap_flag` is sampled low.
- **Overflow (DEPTH=4, `per_ready`=0):** captures 0, 2, 5, 9, 14, 4 →
  - FIFO holds 2, 3, 4, 5; the sixth-capture period 6 is dropped and `ovf`=1.
  - Then assert `per_ready` → entries drain in order 2, 3, 4, 5.
  - Then `clr_ovf` → `ovf`=0.
- **Reset mid-WAIT_CLR:** assert `rst` while `cap_ack`=1 →
  - `cap_ack`=0 immediately and `per_valid`=0.
  - Next captures 4 and 9 yield a single entry of 5.
- **With `CPM_MINMAX_EN`:** periods 8, 3, 12 → `per_min`=3, `per_max`=12. `clr_ovf` → `per_min`=15, `per_max`=0.
